// File: rtl/pump_sched_pkg.sv
// Shared definitions for the pump scheduler.
// Provides the FSM state type, the tank count and tank-index type, the
// default timing parameters and a one-hot helper for per-tank vectors.
package pump_sched_pkg;

    localparam int unsigned NTANK = 2;
    localparam int unsigned TW    = $clog2(NTANK);

    typedef logic [TW-1:0] tank_t;

    localparam int unsigned DEF_SETTLE_CYC = 4;
    localparam int unsigned DEF_MIN_ON     = 8;
    localparam int unsigned DEF_MAX_ON     = 64;
    localparam int unsigned DEF_CW         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FILL   = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic [NTANK-1:0] tank_bit(input tank_t idx);
        logic [NTANK-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pump_sched_if.sv
// Sensor/actuator bundle between the level sensors, the pump scheduler and
// the pump/valve drivers.
//   sr      source reservoir has water
//   lo, hi  per-tank level at/above low and high marks
//   err_clr clear all latched errors
//   pump    pump drive
//   valve   per-tank inlet valve (one-hot or zero)
//   err     per-tank latched error
//   busy    fill cycle in progress
// master: sensor/control side; slave: the scheduler.
interface pump_sched_if;
    import pump_sched_pkg::*;

    logic             sr;
    logic [NTANK-1:0] lo;
    logic [NTANK-1:0] hi;
    logic             err_clr;
    logic             pump;
    logic [NTANK-1:0] valve;
    logic [NTANK-1:0] err;
    logic             busy;

    modport master (
        output sr, lo, hi, err_clr,
        input  pump, valve, err, busy
    );

    modport slave (
        input  sr, lo, hi, err_clr,
        output pump, valve, err, busy
    );

endinterface

// File: rtl/pump_sched_cyc_timer.sv
// Cycle timer for the pump scheduler.
// CW-bit counter with synchronous clear and enable, plus terminal compares:
//   clk, rst_n   clock, synchronous active-low reset
//   clr, en      clear to zero (priority) / increment
//   settle_done  count = SETTLE_CYC-1
//   min_done     count+1 >= MIN_ON
//   max_hit      count+1 = MAX_ON
module pump_sched_cyc_timer #(
    parameter int unsigned CW         = 8,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned MIN_ON     = 8,
    parameter int unsigned MAX_ON     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic settle_done,
    output logic min_done,
    output logic max_hit
);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] MIN_LAST    = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] MAX_LAST    = CW'(MAX_ON - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Compares against N-1 so the FSM sees "this edge completes N cycles".
    assign settle_done = (cnt == SETTLE_LAST);
    assign min_done    = (cnt >= MIN_LAST);
    assign max_hit     = (cnt == MAX_LAST);

endmodule

// File: rtl/pump_sched.sv
// Pump scheduler: one supply pump shared between NTANK tanks.
// Round-robin arbitration between low tanks, then valve open -> settle ->
// pump on -> pump off -> valve close. Dry-run protection on the source
// reservoir and per-tank latched sensor-fault / timeout errors.
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     pump_sched_if slave: sr, lo, hi, err_clr in; pump, valve, err,
//           busy out (all outputs registered)
module pump_sched
    import pump_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned MIN_ON     = DEF_MIN_ON,
    parameter int unsigned MAX_ON     = DEF_MAX_ON,
    parameter int unsigned CW         = DEF_CW
) (
    input  logic         clk,
    input  logic         rst_n,
    pump_sched_if.slave  bus
);

    state_t           state;
    tank_t            g;
    tank_t            last;
    tank_t            nxt;
    tank_t            pick;
    logic [NTANK-1:0] req;
    logic [NTANK-1:0] fault;
    logic [NTANK-1:0] tmo_set;
    logic             tmr_clr;
    logic             tmr_en;
    logic             settle_done;
    logic             min_done;
    logic             max_hit;

    assign fault = bus.hi & ~bus.lo;
    assign req   = ~bus.lo & ~bus.err;

    // Round robin: the tank after last wins if it asks, else the other one.
    assign nxt  = ~last;
    assign pick = req[nxt] ? nxt : last;

    always_comb begin
        tmo_set = '0;
        if (state == FILL && max_hit) begin
            tmo_set[g] = 1'b1;
        end
    end

    // Counter runs only through SETTLE and FILL; it is zero on entry to each.
    always_comb begin
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        unique case (state)
            SETTLE: begin
                tmr_clr = settle_done;
                tmr_en  = ~settle_done;
            end
            FILL: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
            end
            default: ;
        endcase
    end

    pump_sched_cyc_timer #(
        .CW         (CW),
        .SETTLE_CYC (SETTLE_CYC),
        .MIN_ON     (MIN_ON),
        .MAX_ON     (MAX_ON)
    ) u_cyc_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (tmr_clr),
        .en          (tmr_en),
        .settle_done (settle_done),
        .min_done    (min_done),
        .max_hit     (max_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            last      <= tank_t'(NTANK - 1);
            bus.pump  <= 1'b0;
            bus.valve <= '0;
            bus.err   <= '0;
            bus.busy  <= 1'b0;
        end else begin
            // A new fault or timeout outranks a simultaneous clear.
            bus.err <= (bus.err & ~{NTANK{bus.err_clr}}) | fault | tmo_set;

            unique case (state)
                IDLE: begin
                    if (bus.sr && (|req)) begin
                        g         <= pick;
                        bus.valve <= tank_bit(pick);
                        bus.busy  <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!bus.sr || fault[g]) begin
                        state <= STOP;
                    end else if (settle_done) begin
                        bus.pump <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (!bus.sr || fault[g] || (bus.hi[g] && min_done) || max_hit) begin
                        bus.pump <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    bus.valve <= '0;
                    bus.busy  <= 1'b0;
                    last      <= g;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pump_sched.sv
// Self-checking bench for pump_sched: table of {inputs, expected outputs}
// rows replayed through a scoreboard queue, plus hand-written sequences for
// timeout and reset during a fill.
module tb_pump_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pump_sched_if bus ();

    pump_sched #(
        .SETTLE_CYC (4),
        .MIN_ON     (8),
        .MAX_ON     (64),
        .CW         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        rst_n;
        logic        sr;
        logic [1:0]  lo;
        logic [1:0]  hi;
        logic        clr;
        int unsigned n;
        logic        pump;
        logic [1:0]  valve;
        logic [1:0]  err;
        logic        busy;
    } vec_t;

    typedef struct packed {
        logic       chk;
        logic       pump;
        logic [1:0] valve;
        logic [1:0] err;
        logic       busy;
    } exp_t;

    vec_t  vecs[$];
    string vnames[$];
    exp_t  sbq[$];
    string snames[$];

    int checks   = 0;
    int failures = 0;

    exp_t  mon_e;
    string mon_n;

    // Scoreboard consumer: one expectation per clock edge.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            mon_n = snames.pop_front();
            if (mon_e.chk) begin
                checks++;
                if ({bus.pump, bus.valve, bus.err, bus.busy} !==
                    {mon_e.pump, mon_e.valve, mon_e.err, mon_e.busy}) begin
                    failures++;
                    $display("FAIL %s: got pump=%b valve=%b err=%b busy=%b, want pump=%b valve=%b err=%b busy=%b",
                             mon_n, bus.pump, bus.valve, bus.err, bus.busy,
                             mon_e.pump, mon_e.valve, mon_e.err, mon_e.busy);
                end
            end
        end
        checks++;
        if (bus.valve === 2'b11 || (bus.pump === 1'b1 && bus.valve === 2'b00)) begin
            failures++;
            $display("FAIL safety: got pump=%b valve=%b, want valve one-hot/zero and open while pumping",
                     bus.pump, bus.valve);
        end
    end

    function automatic void add(input logic r, input logic s, input logic [1:0] l,
                                input logic [1:0] h, input logic c, input int unsigned n,
                                input logic p, input logic [1:0] v, input logic [1:0] e,
                                input logic b, input string nm);
        vec_t t;
        t.rst_n = r; t.sr = s; t.lo = l; t.hi = h; t.clr = c; t.n = n;
        t.pump = p; t.valve = v; t.err = e; t.busy = b;
        vecs.push_back(t);
        vnames.push_back(nm);
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic step(input logic r, input logic s, input logic [1:0] l,
                        input logic [1:0] h, input logic c, input logic chk,
                        input logic p, input logic [1:0] v, input logic [1:0] e,
                        input logic b, input string nm);
        exp_t x;
        rst_n       = r;
        bus.sr      = s;
        bus.lo      = l;
        bus.hi      = h;
        bus.err_clr = c;
        x.chk = chk; x.pump = p; x.valve = v; x.err = e; x.busy = b;
        sbq.push_back(x);
        snames.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string nm, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Hold inputs until pump reaches lvl, with a cycle bound.
    task automatic run_until_pump(input logic s, input logic [1:0] l, input logic [1:0] h,
                                  input logic lvl, input int unsigned bound,
                                  output int unsigned cyc);
        cyc = 0;
        while (bus.pump !== lvl && cyc < bound) begin
            step(1'b1, s, l, h, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "wait");
            cyc++;
        end
        checks++;
        if (bus.pump !== lvl) begin
            failures++;
            $display("FAIL wait_pump: got pump=%b after %0d cycles, want %b", bus.pump, cyc, lvl);
        end
    endtask

    int unsigned cyc;

    initial begin
        bus.sr = 1'b0; bus.lo = 2'b11; bus.hi = 2'b00; bus.err_clr = 1'b0;

        // single request with hysteresis on hi[0]
        add(0,1,2'b11,2'b00,0,2, 0,2'b00,2'b00,0,"sr_reset");
        add(1,1,2'b10,2'b00,0,1, 0,2'b01,2'b00,1,"sr_grant");
        add(1,1,2'b10,2'b00,0,3, 0,2'b01,2'b00,1,"sr_settle");
        add(1,1,2'b10,2'b00,0,1, 1,2'b01,2'b00,1,"sr_pump_on");
        add(1,1,2'b10,2'b00,0,1, 1,2'b01,2'b00,1,"sr_fill1");
        add(1,1,2'b11,2'b01,0,2, 1,2'b01,2'b00,1,"sr_hi_early");
        add(1,1,2'b11,2'b00,0,2, 1,2'b01,2'b00,1,"sr_hi_dropped");
        add(1,1,2'b11,2'b01,0,2, 1,2'b01,2'b00,1,"sr_min_hold");
        add(1,1,2'b11,2'b01,0,1, 0,2'b01,2'b00,1,"sr_pump_off");
        add(1,1,2'b11,2'b01,0,1, 0,2'b00,2'b00,0,"sr_valve_off");
        add(1,1,2'b11,2'b01,0,3, 0,2'b00,2'b00,0,"sr_idle");
        // tie and alternation
        add(0,1,2'b00,2'b00,0,1, 0,2'b00,2'b00,0,"tie_reset");
        add(1,1,2'b00,2'b00,0,1, 0,2'b01,2'b00,1,"tie_first_t0");
        add(1,1,2'b00,2'b00,0,4, 1,2'b01,2'b00,1,"tie_t0_pump");
        add(1,1,2'b01,2'b01,0,7, 1,2'b01,2'b00,1,"tie_t0_fill");
        add(1,1,2'b01,2'b01,0,1, 0,2'b01,2'b00,1,"tie_t0_off");
        add(1,1,2'b00,2'b00,0,1, 0,2'b00,2'b00,0,"tie_gap");
        add(1,1,2'b00,2'b00,0,1, 0,2'b10,2'b00,1,"tie_second_t1");
        add(1,1,2'b00,2'b00,0,4, 1,2'b10,2'b00,1,"tie_t1_pump");
        add(1,1,2'b10,2'b10,0,7, 1,2'b10,2'b00,1,"tie_t1_fill");
        add(1,1,2'b10,2'b10,0,1, 0,2'b10,2'b00,1,"tie_t1_off");
        add(1,1,2'b00,2'b00,0,1, 0,2'b00,2'b00,0,"tie_gap2");
        add(1,1,2'b00,2'b00,0,1, 0,2'b01,2'b00,1,"tie_third_t0");
        // dry run
        add(0,1,2'b10,2'b00,0,1, 0,2'b00,2'b00,0,"dry_reset");
        add(1,1,2'b10,2'b00,0,1, 0,2'b01,2'b00,1,"dry_grant");
        add(1,1,2'b10,2'b00,0,4, 1,2'b01,2'b00,1,"dry_pump_on");
        add(1,1,2'b10,2'b00,0,2, 1,2'b01,2'b00,1,"dry_fill");
        add(1,0,2'b10,2'b00,0,1, 0,2'b01,2'b00,1,"dry_pump_cut");
        add(1,0,2'b10,2'b00,0,1, 0,2'b00,2'b00,0,"dry_valve_off");
        add(1,0,2'b10,2'b00,0,5, 0,2'b00,2'b00,0,"dry_hold_idle");
        add(1,1,2'b10,2'b00,0,1, 0,2'b01,2'b00,1,"dry_resume");
        // sensor fault on idle tank, clear racing a persisting fault
        add(0,0,2'b00,2'b01,0,1, 0,2'b00,2'b00,0,"sf_reset");
        add(1,0,2'b00,2'b01,0,1, 0,2'b00,2'b01,0,"sf_latch");
        add(1,1,2'b00,2'b01,1,1, 0,2'b10,2'b01,1,"sf_clr_vs_set");
        add(1,1,2'b00,2'b01,0,4, 1,2'b10,2'b01,1,"sf_t1_pump");
        add(1,1,2'b10,2'b11,0,7, 1,2'b10,2'b01,1,"sf_t1_fill");
        add(1,1,2'b10,2'b11,0,1, 0,2'b10,2'b01,1,"sf_t1_off");
        add(1,1,2'b10,2'b11,0,1, 0,2'b00,2'b01,0,"sf_t1_stop");
        add(1,1,2'b10,2'b11,0,3, 0,2'b00,2'b01,0,"sf_t0_locked");
        add(1,1,2'b11,2'b00,1,1, 0,2'b00,2'b00,0,"sf_clear");
        // sensor fault on the granted tank during fill, before MIN_ON
        add(0,1,2'b10,2'b00,0,1, 0,2'b00,2'b00,0,"ff_reset");
        add(1,1,2'b10,2'b00,0,1, 0,2'b01,2'b00,1,"ff_grant");
        add(1,1,2'b10,2'b00,0,4, 1,2'b01,2'b00,1,"ff_pump_on");
        add(1,1,2'b10,2'b01,0,1, 0,2'b01,2'b01,1,"ff_fault_stop");
        add(1,1,2'b10,2'b00,0,1, 0,2'b00,2'b01,0,"ff_valve_off");
        add(1,1,2'b10,2'b00,0,2, 0,2'b00,2'b01,0,"ff_no_regrant");

        for (int i = 0; i < vecs.size(); i++) begin
            for (int unsigned k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].rst_n, vecs[i].sr, vecs[i].lo, vecs[i].hi, vecs[i].clr,
                     (k == vecs[i].n - 1), vecs[i].pump, vecs[i].valve, vecs[i].err,
                     vecs[i].busy, vnames[i]);
            end
        end

        // timeout: tank 0 never reaches hi
        step(0,1,2'b10,2'b00,0, 1, 0,2'b00,2'b00,0,"to_reset");
        run_until_pump(1'b1, 2'b10, 2'b00, 1'b1, 20, cyc);
        check_val("to_pump_delay", cyc, 5);
        run_until_pump(1'b1, 2'b10, 2'b00, 1'b0, 200, cyc);
        check_val("to_pump_cycles", cyc, 64);
        check_val("to_err_set", 32'(bus.err), 1);
        check_val("to_valve_held", 32'(bus.valve), 1);
        step(1,1,2'b10,2'b00,0, 1, 0,2'b00,2'b01,0,"to_stop");
        for (int i = 0; i < 8; i++) begin
            step(1,1,2'b10,2'b00,0, (i == 7), 0,2'b00,2'b01,0,"to_no_regrant");
        end
        step(1,1,2'b10,2'b00,1, 1, 0,2'b00,2'b00,0,"to_clear");
        step(1,1,2'b10,2'b00,0, 1, 0,2'b01,2'b00,1,"to_regrant");

        // reset during tank 1 fill, after tank 0 was served
        step(0,1,2'b10,2'b00,0, 1, 0,2'b00,2'b00,0,"rm_reset");
        run_until_pump(1'b1, 2'b10, 2'b00, 1'b1, 20, cyc);
        run_until_pump(1'b1, 2'b11, 2'b01, 1'b0, 20, cyc);
        check_val("rm_t0_min_on", cyc, 8);
        run_until_pump(1'b1, 2'b01, 2'b00, 1'b1, 20, cyc);
        check_val("rm_t1_granted", 32'(bus.valve), 2);
        step(1,1,2'b01,2'b00,0, 0, 0,2'b00,2'b00,0,"rm_fill");
        step(1,1,2'b01,2'b00,0, 0, 0,2'b00,2'b00,0,"rm_fill");
        step(0,1,2'b00,2'b00,0, 1, 0,2'b00,2'b00,0,"rm_reset_mid_fill");
        step(1,1,2'b00,2'b00,0, 1, 0,2'b01,2'b00,1,"rm_first_grant_t0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
